// File: rtl/acpo_readout_ctrl.sv
// Sequences layer readout from the SA/address buffers or the FC buffer into a valid/ready stream.
// Optional stall counter enabled by `define ACPO_RD_STALL_CNT_EN.
module acpo_readout_ctrl #(
    parameter int SRAM_DEPTH    = 1024,
    parameter int BAND_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10,
    localparam int WW = $clog2(SRAM_DEPTH),
    localparam int CW = WW + 1,
    localparam int BW = $clog2(BAND_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [CW-1:0]            word_cnt_i,
    input  logic [BAND_WIDTH-1:0]    pool_last_i,
    input  logic                     act_last_fc_i,
    output logic                     enb_d_sa_o,
    output logic                     enb_a_o,
    output logic [WW+BW-1:0]         addrb_sa_o,
    output logic                     enb_d_fc_o,
    output logic [WW-1:0]            addrb_fc_o,
    input  logic [DATA_WIDTH-1:0]    dob_d_sa_i,
    input  logic [ADDRESS_WIDTH-1:0] dob_a_i,
    input  logic [DATA_WIDTH-1:0]    dob_d_fc_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [DATA_WIDTH-1:0]    m_data_o,
    output logic [ADDRESS_WIDTH-1:0] m_addr_o,
    output logic                     m_last_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overrun_o,
    output logic [15:0]              rd_stall_cnt_o
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic                     last;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } beat_t;

    state_t                state_q;
    logic                  mode_q;
    logic [CW-1:0]         nwords_q;
    logic [CW-1:0]         word_q;
    logic [BW-1:0]         bank_q;
    logic [BAND_WIDTH-1:0] seen_q;
    logic                  pend_q;
    logic                  pend_last_q;
    beat_t                 fifo_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q;
    logic                  done_q;
    logic                  overrun_q;

    logic       pop;
    logic       space;
    logic       issue;
    logic       last_word;
    logic       last_rd;
    logic       seen_all;
    logic       start_acc;
    logic [2:0] occ;
    beat_t      cap;

    // A slot is free if the beat popped this cycle makes room for the read whose data lands next cycle.
    always_comb begin
        pop       = (cnt_q != 2'd0) && m_ready_i;
        occ       = {1'b0, cnt_q} + {2'b00, pend_q};
        space     = occ < (3'd2 + {2'b00, pop});
        issue     = (state_q == S_READ) && space;
        last_word = (word_q == nwords_q - CW'(1));
        last_rd   = last_word && (mode_q || (bank_q == BW'(BAND_WIDTH - 1)));
        seen_all  = &(seen_q | pool_last_i);
        start_acc = (state_q == S_IDLE) && start_i;
        cap.last  = pend_last_q;
        cap.addr  = mode_q ? '0 : dob_a_i;
        cap.data  = mode_q ? dob_d_fc_i : dob_d_sa_i;
    end

    assign enb_d_sa_o = issue && !mode_q;
    assign enb_a_o    = issue && !mode_q;
    assign enb_d_fc_o = issue && mode_q;
    assign addrb_sa_o = {bank_q, word_q[WW-1:0]};
    assign addrb_fc_o = word_q[WW-1:0];
    assign m_valid_o  = (cnt_q != 2'd0);
    assign m_data_o   = fifo_q[rd_ptr_q].data;
    assign m_addr_o   = fifo_q[rd_ptr_q].addr;
    assign m_last_o   = fifo_q[rd_ptr_q].last;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            nwords_q    <= '0;
            word_q      <= '0;
            bank_q      <= '0;
            seen_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            pend_q      <= issue;
            pend_last_q <= issue && last_rd;
            cnt_q       <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
            if (pend_q) begin
                fifo_q[wr_ptr_q] <= cap;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if ((state_q != S_WAIT) && ((|pool_last_i) || act_last_fc_i)) overrun_q <= 1'b1;
            if (issue) begin
                if (last_word) begin
                    word_q <= '0;
                    bank_q <= bank_q + BW'(1);
                end else begin
                    word_q <= word_q + CW'(1);
                end
            end
            case (state_q)
                S_IDLE: if (start_i) begin
                    mode_q    <= mode_i;
                    nwords_q  <= word_cnt_i;
                    word_q    <= '0;
                    bank_q    <= '0;
                    seen_q    <= '0;
                    overrun_q <= 1'b0;
                    if (word_cnt_i == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mode_q) begin
                        if (act_last_fc_i) state_q <= S_READ;
                    end else begin
                        seen_q <= seen_q | pool_last_i;
                        if (seen_all) state_q <= S_READ;
                    end
                end
                S_READ:  if (issue && last_rd) state_q <= S_DRAIN;
                S_DRAIN: if (pop && fifo_q[rd_ptr_q].last) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ACPO_RD_STALL_CNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (m_valid_o && !m_ready_i && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end
    assign rd_stall_cnt_o = stall_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign rd_stall_cnt_o   = 16'd0;
`endif

endmodule

// File: tb/tb_acpo_readout_ctrl.sv
// Directed bench for acpo_readout_ctrl: BRAM models, beat scoreboard, SA/FC/zero/overrun/reset cases.
module tb_acpo_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        mode_i;
    logic [10:0] word_cnt_i;
    logic [15:0] pool_last_i;
    logic        act_last_fc_i;
    logic        enb_d_sa_o, enb_a_o, enb_d_fc_o;
    logic [13:0] addrb_sa_o;
    logic [9:0]  addrb_fc_o;
    logic [7:0]  dob_d_sa_i;
    logic [9:0]  dob_a_i;
    logic [7:0]  dob_d_fc_i;
    logic        m_valid_o, m_ready_i, m_last_o, busy_o, done_o, overrun_o;
    logic [7:0]  m_data_o;
    logic [9:0]  m_addr_o;
    logic [15:0] rd_stall_cnt_o;

    always #5 clk = ~clk;

    acpo_readout_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .word_cnt_i(word_cnt_i),
        .pool_last_i(pool_last_i), .act_last_fc_i(act_last_fc_i),
        .enb_d_sa_o(enb_d_sa_o), .enb_a_o(enb_a_o), .addrb_sa_o(addrb_sa_o),
        .enb_d_fc_o(enb_d_fc_o), .addrb_fc_o(addrb_fc_o),
        .dob_d_sa_i(dob_d_sa_i), .dob_a_i(dob_a_i), .dob_d_fc_i(dob_d_fc_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_addr_o(m_addr_o),
        .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
        .rd_stall_cnt_o(rd_stall_cnt_o)
    );

    // Buffer contents: a fixed function of the read address.
    function automatic logic [7:0] dsa(input logic [13:0] a);
        return a[7:0] ^ {a[13:10], a[13:10]} ^ 8'h5A;
    endfunction
    function automatic logic [9:0] asa(input logic [13:0] a);
        return a[9:0] ^ {a[13:10], 6'h2B};
    endfunction
    function automatic logic [7:0] dfc(input logic [9:0] a);
        return a[7:0] + 8'h31;
    endfunction

    always @(posedge clk) begin
        if (enb_d_sa_o) dob_d_sa_i <= dsa(addrb_sa_o);
        if (enb_a_o)    dob_a_i    <= asa(addrb_sa_o);
        if (enb_d_fc_o) dob_d_fc_i <= dfc(addrb_fc_o);
    end

    typedef struct packed {
        logic [7:0] d;
        logic [9:0] a;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   beat_cnt = 0;
    int   exp_stall = 0;
    bit   exp_done_next = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake, checks done_o follows the last beat.
    always @(negedge clk) begin
        if (rst) begin
            if (exp_done_next) chk("done_after_last", {31'd0, done_o}, 32'd1);
            exp_done_next = 1'b0;
            if (m_valid_o && m_ready_i) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    chk("extra_beat", {31'd0, m_valid_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("beat_data", {24'd0, m_data_o}, {24'd0, e.d});
                    chk("beat_addr", {22'd0, m_addr_o}, {22'd0, e.a});
                    chk("beat_last", {31'd0, m_last_o}, {31'd0, e.l});
                    if (e.l) exp_done_next = 1'b1;
                end
            end
            if (m_valid_o && !m_ready_i) exp_stall++;
        end
    end

    task automatic push_sa(input int n);
        for (int b = 0; b < 16; b++) begin
            for (int w = 0; w < n; w++) begin
                logic [13:0] a;
                exp_t e;
                a = {b[3:0], w[9:0]};
                e.d = dsa(a);
                e.a = asa(a);
                e.l = (b == 15) && (w == n - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic push_fc(input int n);
        for (int w = 0; w < n; w++) begin
            exp_t e;
            e.d = dfc(w[9:0]);
            e.a = 10'd0;
            e.l = (w == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input logic mode, input int n);
        @(posedge clk); #1;
        start_i    = 1'b1;
        mode_i     = mode;
        word_cnt_i = n[10:0];
        beat_cnt   = 0;
        exp_stall  = 0;
        @(posedge clk); #1;
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int inj);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            m_ready_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pool_last_i = (i == inj) ? 16'h0008 : 16'h0000;
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("sb_empty", sb.size(), 32'd0);
        @(posedge clk); #1;
        pool_last_i = '0;
        m_ready_i   = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; mode_i = 1'b0; word_cnt_i = '0;
        pool_last_i = '0; act_last_fc_i = 1'b0; m_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_overrun", {31'd0, overrun_o}, 32'd0);
        chk("rst_enb", {29'd0, enb_d_sa_o, enb_a_o, enb_d_fc_o}, 32'd0);
        chk("rst_stall", {16'd0, rd_stall_cnt_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // SA N=4, all lasts together, full throughput
        push_sa(4);
        do_start(1'b0, 4);
        pool_last_i = 16'hFFFF;
        @(negedge clk);
        chk("t1_busy", {31'd0, busy_o}, 32'd1);
        chk("t1_no_enb_yet", {31'd0, enb_d_sa_o}, 32'd0);
        @(posedge clk); #1;
        pool_last_i = '0;
        @(negedge clk);
        chk("t1_first_enb", {30'd0, enb_d_sa_o, enb_a_o}, 32'd3);
        chk("t1_first_addr", {18'd0, addrb_sa_o}, 32'd0);
        @(negedge clk);
        chk("t1_valid_c1", {31'd0, m_valid_o}, 32'd0);
        @(negedge clk);
        chk("t1_valid_c2", {31'd0, m_valid_o}, 32'd1);
        wait_done(1'b0, -1);
        chk("t1_beats", beat_cnt, 32'd64);
        chk("t1_overrun", {31'd0, overrun_o}, 32'd0);

        // SA staggered lasts, then overrun pulse during READ
        push_sa(4);
        do_start(1'b0, 4);
        for (int l = 0; l < 16; l++) begin
            pool_last_i = 16'h0001 << l;
            @(negedge clk);
            chk("t2_no_read_early", {31'd0, enb_d_sa_o}, 32'd0);
            @(posedge clk); #1;
        end
        pool_last_i = '0;
        wait_done(1'b0, 20);
        chk("t2_beats", beat_cnt, 32'd64);
        chk("t2_overrun_set", {31'd0, overrun_o}, 32'd1);

        // FC N=10, random ready; start clears overrun
        push_fc(10);
        do_start(1'b1, 10);
        act_last_fc_i = 1'b1;
        @(negedge clk);
        chk("t3_overrun_clr", {31'd0, overrun_o}, 32'd0);
        @(posedge clk); #1;
        act_last_fc_i = 1'b0;
        wait_done(1'b1, -1);
        chk("t3_beats", beat_cnt, 32'd10);
`ifdef ACPO_RD_STALL_CNT_EN
        chk("t3_stall_cnt", {16'd0, rd_stall_cnt_o}, exp_stall);
`else
        chk("t3_stall_cnt", {16'd0, rd_stall_cnt_o}, 32'd0);
`endif

        // zero-word start
        @(posedge clk); #1;
        start_i = 1'b1; mode_i = 1'b0; word_cnt_i = '0; beat_cnt = 0;
        @(negedge clk);
        chk("t4_done_early", {31'd0, done_o}, 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("t4_done", {31'd0, done_o}, 32'd1);
        chk("t4_no_valid", {31'd0, m_valid_o}, 32'd0);
        @(negedge clk);
        chk("t4_done_pulse", {31'd0, done_o}, 32'd0);
        chk("t4_idle", {31'd0, busy_o}, 32'd0);
        chk("t4_beats", beat_cnt, 32'd0);

        // reset during READ, then full readout again
        push_sa(4);
        do_start(1'b0, 4);
        pool_last_i = 16'hFFFF;
        @(posedge clk); #1;
        pool_last_i = '0;
        for (int i = 0; i < 200 && beat_cnt < 20; i++) @(negedge clk);
        chk("t5_reached_20", {31'd0, beat_cnt >= 20}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t5_rst_outs", {25'd0, m_valid_o, enb_d_sa_o, enb_a_o, busy_o, done_o, m_last_o, overrun_o}, 32'd0);
        chk("t5_rst_data", {4'd0, m_data_o, m_addr_o, 10'd0}, 32'd0);
        chk("t5_rst_addr", {18'd0, addrb_sa_o}, 32'd0);
        sb.delete();
        exp_done_next = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        push_sa(4);
        do_start(1'b0, 4);
        pool_last_i = 16'hFFFF;
        @(posedge clk); #1;
        pool_last_i = '0;
        wait_done(1'b0, -1);
        chk("t5_beats", beat_cnt, 32'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
